dsp_2_18x18s: RTL and testbench
===============================

DSP_2_18X18S -- requirements
Module: dsp_2_18x18s

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FAMILY, "Agilex", target device family; selects implementation only and SHALL NOT change cycle behaviour.
- LATENCY, 3, register stages from input sample to output.
- AX_WIDTH, 18, width of operand ax.
- AY_WIDTH, 18, width of operand ay.
- BX_WIDTH, 18, width of operand bx.
- BY_WIDTH, 18, width of operand by.
- RESULT_A_WIDTH, 36, width of resulta.
- RESULT_B_WIDTH, 36, width of resultb.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- ax, in, AX_WIDTH, signed multiplicand, lane A.
- ay, in, AY_WIDTH, signed multiplier, lane A.
- bx, in, BX_WIDTH, signed multiplicand, lane B.
- by, in, BY_WIDTH, signed multiplier, lane B.
- resulta, out, RESULT_A_WIDTH, signed product, lane A.
- resultb, out, RESULT_B_WIDTH, signed product, lane B.

REQ-003 The block has one clock, clk; reset rst_n is asynchronous and active-low.

REQ-004 Legal ranges:
- LATENCY 1..4.
- Operand widths 1..18.
- RESULT_A_WIDTH >= AX_WIDTH+AY_WIDTH; RESULT_B_WIDTH >= BX_WIDTH+BY_WIDTH.
- Illegal values SHALL stop elaboration with an error.

Function
REQ-005 resulta SHALL equal the two's-complement product ax*ay; resultb SHALL equal bx*by.
REQ-006 Products SHALL be exact, with no rounding or saturation; the product is sign-extended when the result width exceeds the operand width sum.
REQ-007 Lanes A and B SHALL be fully independent; one lane's values SHALL never affect the other lane.
REQ-008 Operands sampled at rising edge k SHALL appear on the outputs after rising edge k+LATENCY-1 and hold until the next edge.
- Example, LATENCY=3: sampled at edge 0, visible after edge 2, checkable at edge 3.
REQ-009 The pipeline SHALL accept a new operand set every cycle (throughput 1/cycle), with no stall, enable or valid signals.
REQ-010 Outputs SHALL be registered; there is no combinational path from inputs to outputs.
REQ-011 Corner case: -2^17 * -2^17 = +2^34 SHALL be represented correctly without overflow at the default widths.

Reset
REQ-012 While rst_n=0, all pipeline registers SHALL clear asynchronously and resulta/resultb SHALL read 0.
REQ-013 After rst_n deasserts, outputs SHALL read 0 until the first post-reset sample has propagated (LATENCY-1 edges).
REQ-014 Reset asserted mid-stream SHALL discard all in-flight products; no pre-reset product SHALL ever appear after reset.

Structure
REQ-015 A shared package dsp_pkg SHALL hold:
- default width constants (18, 36);
- LATENCY limits (1, 4);
- the FAMILY string constants.
REQ-016 The lane datapath SHALL live in one sub-module, dsp_mult_lane: a parameterised signed multiply plus a LATENCY-stage register pipe with async reset.
REQ-017 The top SHALL instantiate dsp_mult_lane twice, once per lane.
REQ-018 A FAMILY-specific hard-DSP primitive MAY be generated; a behavioural fallback SHALL be used for any unrecognised FAMILY, with identical cycle behaviour.

Verification
REQ-019 Bench scenarios, one per line:
- Basic: ax=3, ay=-5, bx=100, by=200 at edge 0 -> resulta=-15, resultb=20000 after edge 2 (LATENCY=3).
- Extremes: ax=ay=-131072; bx=131071, by=-131072 -> resulta=17179869184, resultb=-17179738112.
- Streaming: random operands every cycle for 1000 cycles -> each output matches a LATENCY-deep reference delay line every cycle (compare with !==, X is a failure).
- Reset mid-stream: assert rst_n=0 between edges -> outputs 0 immediately; after release, outputs stay 0 until the first new product, with no stale value appearing.
- Lane isolation: hold bx=7, by=9 while randomising ax/ay -> resultb constant at 63.
- Parameter sweep: LATENCY=1 and 4 -> delay exactly LATENCY-1 edges post-sample, per REQ-008.

Source files
------------

// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared constants for the dual 18x18 signed multiplier block:
//   - default operand/result widths
//   - legal LATENCY range
//   - device family name strings recognised by the lane datapath
// ---------------------------------------------------------------------------
package dsp_pkg;

    localparam int DSP_DEFAULT_OPERAND_W = 18;
    localparam int DSP_DEFAULT_RESULT_W  = 36;
    localparam int DSP_DEFAULT_LATENCY   = 3;

    localparam int DSP_LATENCY_MIN       = 1;
    localparam int DSP_LATENCY_MAX       = 4;
    localparam int DSP_OPERAND_W_MAX     = 18;

    localparam string FAMILY_AGILEX      = "Agilex";
    localparam string FAMILY_STRATIX10   = "Stratix 10";
    localparam string FAMILY_ARRIA10     = "Arria 10";
    localparam string FAMILY_CYCLONE10GX = "Cyclone 10 GX";

endpackage : dsp_pkg

// File: rtl/dsp_mult_lane.sv
// ---------------------------------------------------------------------------
// dsp_mult_lane
// One signed multiplier lane: result_o = x_i * y_i, exact, sign-extended to
// RESULT_WIDTH, delivered LATENCY register stages after the operands are
// sampled.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears every stage
//   x_i      - signed multiplicand, X_WIDTH bits
//   y_i      - signed multiplier,   Y_WIDTH bits
//   result_o - signed product, RESULT_WIDTH bits (registered)
// ---------------------------------------------------------------------------
module dsp_mult_lane
    import dsp_pkg::*;
#(
    parameter string FAMILY       = FAMILY_AGILEX,
    parameter int    LATENCY      = DSP_DEFAULT_LATENCY,
    parameter int    X_WIDTH      = DSP_DEFAULT_OPERAND_W,
    parameter int    Y_WIDTH      = DSP_DEFAULT_OPERAND_W,
    parameter int    RESULT_WIDTH = DSP_DEFAULT_RESULT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [X_WIDTH-1:0]      x_i,
    input  logic signed [Y_WIDTH-1:0]      y_i,
    output logic signed [RESULT_WIDTH-1:0] result_o
);

    // Elaboration-time legality checks.
    if (LATENCY < DSP_LATENCY_MIN || LATENCY > DSP_LATENCY_MAX) begin : g_bad_latency
        $error("dsp_mult_lane: LATENCY %0d outside %0d..%0d",
               LATENCY, DSP_LATENCY_MIN, DSP_LATENCY_MAX);
    end
    if (X_WIDTH < 1 || X_WIDTH > DSP_OPERAND_W_MAX ||
        Y_WIDTH < 1 || Y_WIDTH > DSP_OPERAND_W_MAX) begin : g_bad_width
        $error("dsp_mult_lane: operand widths %0d/%0d outside 1..%0d",
               X_WIDTH, Y_WIDTH, DSP_OPERAND_W_MAX);
    end
    if (RESULT_WIDTH < X_WIDTH + Y_WIDTH) begin : g_bad_result
        $error("dsp_mult_lane: RESULT_WIDTH %0d < %0d", RESULT_WIDTH, X_WIDTH + Y_WIDTH);
    end

    // On hard-DSP families one stage is spent on operand registers so the
    // tools can pack them into the DSP input registers. The remaining stages
    // sit after the multiplier. Total depth is LATENCY either way, so cycle
    // behaviour does not depend on FAMILY.
    localparam bit FAMILY_KNOWN = (FAMILY == FAMILY_AGILEX)    ||
                                  (FAMILY == FAMILY_STRATIX10) ||
                                  (FAMILY == FAMILY_ARRIA10)   ||
                                  (FAMILY == FAMILY_CYCLONE10GX);
    localparam int IN_REGS   = (FAMILY_KNOWN && LATENCY >= 2) ? 1 : 0;
    localparam int OUT_STAGES = LATENCY - IN_REGS;

    logic signed [X_WIDTH-1:0] x_op;
    logic signed [Y_WIDTH-1:0] y_op;

    if (IN_REGS != 0) begin : g_in_regs
        logic signed [X_WIDTH-1:0] x_q;
        logic signed [Y_WIDTH-1:0] y_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q <= '0;
                y_q <= '0;
            end else begin
                x_q <= x_i;
                y_q <= y_i;
            end
        end

        assign x_op = x_q;
        assign y_op = y_q;
    end else begin : g_no_in_regs
        assign x_op = x_i;
        assign y_op = y_i;
    end

    // Sign-extend both operands to the result width first; the true product
    // always fits, so the truncated RESULT_WIDTH product is exact.
    logic signed [RESULT_WIDTH-1:0] x_ext;
    logic signed [RESULT_WIDTH-1:0] y_ext;
    logic signed [RESULT_WIDTH-1:0] product_d;

    assign x_ext     = RESULT_WIDTH'(x_op);
    assign y_ext     = RESULT_WIDTH'(y_op);
    assign product_d = x_ext * y_ext;

    logic signed [RESULT_WIDTH-1:0] stage_q [OUT_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= product_d;
            for (int i = 1; i < OUT_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign result_o = stage_q[OUT_STAGES-1];

endmodule : dsp_mult_lane

// File: rtl/dsp_2_18x18s.sv
// ---------------------------------------------------------------------------
// dsp_2_18x18s
// Two independent pipelined signed multipliers (lanes A and B).
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   ax, ay  - lane A signed operands
//   bx, by  - lane B signed operands
//   resulta - ax*ay, LATENCY stages after sampling
//   resultb - bx*by, LATENCY stages after sampling
// ---------------------------------------------------------------------------
module dsp_2_18x18s
    import dsp_pkg::*;
#(
    parameter string FAMILY         = FAMILY_AGILEX,
    parameter int    LATENCY        = DSP_DEFAULT_LATENCY,
    parameter int    AX_WIDTH       = DSP_DEFAULT_OPERAND_W,
    parameter int    AY_WIDTH       = DSP_DEFAULT_OPERAND_W,
    parameter int    BX_WIDTH       = DSP_DEFAULT_OPERAND_W,
    parameter int    BY_WIDTH       = DSP_DEFAULT_OPERAND_W,
    parameter int    RESULT_A_WIDTH = DSP_DEFAULT_RESULT_W,
    parameter int    RESULT_B_WIDTH = DSP_DEFAULT_RESULT_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [AX_WIDTH-1:0]       ax,
    input  logic signed [AY_WIDTH-1:0]       ay,
    input  logic signed [BX_WIDTH-1:0]       bx,
    input  logic signed [BY_WIDTH-1:0]       by,
    output logic signed [RESULT_A_WIDTH-1:0] resulta,
    output logic signed [RESULT_B_WIDTH-1:0] resultb
);

    dsp_mult_lane #(
        .FAMILY       (FAMILY),
        .LATENCY      (LATENCY),
        .X_WIDTH      (AX_WIDTH),
        .Y_WIDTH      (AY_WIDTH),
        .RESULT_WIDTH (RESULT_A_WIDTH)
    ) u_lane_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_i      (ax),
        .y_i      (ay),
        .result_o (resulta)
    );

    dsp_mult_lane #(
        .FAMILY       (FAMILY),
        .LATENCY      (LATENCY),
        .X_WIDTH      (BX_WIDTH),
        .Y_WIDTH      (BY_WIDTH),
        .RESULT_WIDTH (RESULT_B_WIDTH)
    ) u_lane_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_i      (bx),
        .y_i      (by),
        .result_o (resultb)
    );

endmodule : dsp_2_18x18s

// File: tb/tb_dsp_2_18x18s.sv
// ---------------------------------------------------------------------------
// tb_dsp_2_18x18s
// Drives three instances (LATENCY 1, 3, 4) from shared operands and compares
// every output, every cycle, against an arithmetic reference: a short history
// of exact products sampled since the last reset.
// ---------------------------------------------------------------------------
module tb_dsp_2_18x18s;

    logic clk;
    logic rst_n;
    logic signed [17:0] ax, ay, bx, by;
    logic signed [35:0] ra1, rb1, ra3, rb3, ra4, rb4;

    int checks;
    int errors;
    int cycle;

    // Products of operands sampled at each rising edge since reset, oldest first.
    logic signed [35:0] hist_a[$];
    logic signed [35:0] hist_b[$];

    dsp_2_18x18s #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .ax(ax), .ay(ay), .bx(bx), .by(by),
        .resulta(ra1), .resultb(rb1)
    );
    dsp_2_18x18s #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .ax(ax), .ay(ay), .bx(bx), .by(by),
        .resulta(ra3), .resultb(rb3)
    );
    dsp_2_18x18s #(.LATENCY(4), .FAMILY("Unknown")) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .ax(ax), .ay(ay), .bx(bx), .by(by),
        .resulta(ra4), .resultb(rb4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycle,
                     $signed(got), $signed(exp));
        end
    endtask

    function automatic logic signed [35:0] exact_mul(input logic signed [17:0] a,
                                                      input logic signed [17:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[35:0];
    endfunction

    // Value expected on the output of a LATENCY=lat instance right after an edge.
    function automatic logic signed [35:0] expect_out(input int lat, input bit lane_b);
        int n;
        n = hist_a.size();
        if (n < lat) return '0;
        return lane_b ? hist_b[n-lat] : hist_a[n-lat];
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, "_l1a"}, ra1, expect_out(1, 1'b0));
        check_val({tag, "_l1b"}, rb1, expect_out(1, 1'b1));
        check_val({tag, "_l3a"}, ra3, expect_out(3, 1'b0));
        check_val({tag, "_l3b"}, rb3, expect_out(3, 1'b1));
        check_val({tag, "_l4a"}, ra4, expect_out(4, 1'b0));
        check_val({tag, "_l4b"}, rb4, expect_out(4, 1'b1));
    endtask

    // One clock: record what the DUT samples, then check just after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) begin
            hist_a.push_back(exact_mul(ax, ay));
            hist_b.push_back(exact_mul(bx, by));
            if (hist_a.size() > 4) begin
                void'(hist_a.pop_front());
                void'(hist_b.pop_front());
            end
        end
        #1;
        cycle++;
        check_all(tag);
        $display("txn %0d %s ax=%0d ay=%0d bx=%0d by=%0d ra3=%0d rb3=%0d",
                 cycle, tag, ax, ay, bx, by, ra3, rb3);
    endtask

    task automatic randomize_ops();
        ax = 18'($urandom);
        ay = 18'($urandom);
        bx = 18'($urandom);
        by = 18'($urandom);
        // Occasionally hit the most negative / positive operand values.
        if ($urandom_range(0, 15) == 0) ax = -18'sd131072;
        if ($urandom_range(0, 15) == 0) ay = -18'sd131072;
        if ($urandom_range(0, 15) == 0) by = 18'sd131071;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        rst_n  = 1'b0;
        ax = '0; ay = '0; bx = '0; by = '0;

        #2;
        check_all("reset");
        step("in_reset");
        step("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("idle");

        // Basic: one operand set at edge 0, zeros afterwards.
        ax = 18'sd3; ay = -18'sd5; bx = 18'sd100; by = 18'sd200;
        step("basic_e0");
        check_val("basic_l1a", ra1, -36'sd15);
        check_val("basic_l1b", rb1, 36'sd20000);
        ax = '0; ay = '0; bx = '0; by = '0;
        step("basic_e1");
        step("basic_e2");
        check_val("basic_l3a", ra3, -36'sd15);
        check_val("basic_l3b", rb3, 36'sd20000);
        step("basic_e3");
        check_val("basic_l4a", ra4, -36'sd15);
        check_val("basic_l4b", rb4, 36'sd20000);

        // Extremes.
        ax = -18'sd131072; ay = -18'sd131072; bx = 18'sd131071; by = -18'sd131072;
        step("ext_e0");
        ax = '0; ay = '0; bx = '0; by = '0;
        step("ext_e1");
        step("ext_e2");
        check_val("ext_l3a", ra3, 36'sd17179869184);
        check_val("ext_l3b", rb3, -36'sd17179738112);

        // Lane isolation: lane B held, lane A random.
        bx = 18'sd7; by = 18'sd9;
        for (int i = 0; i < 24; i++) begin
            ax = 18'($urandom);
            ay = 18'($urandom);
            step("iso");
            if (i >= 3) begin
                check_val("iso_l1b", rb1, 36'sd63);
                check_val("iso_l3b", rb3, 36'sd63);
                check_val("iso_l4b", rb4, 36'sd63);
            end
        end

        // Streaming, first half.
        for (int i = 0; i < 500; i++) begin
            randomize_ops();
            step("stream");
        end

        // Reset mid-stream, asserted between edges.
        rst_n = 1'b0;
        #1;
        hist_a.delete();
        hist_b.delete();
        check_all("rst_async");
        randomize_ops();
        step("rst_hold");
        randomize_ops();
        step("rst_hold");
        rst_n = 1'b1;
        #1;
        check_all("rst_release");

        // Streaming, second half; the model's empty history enforces zeros
        // until the first post-reset product arrives.
        for (int i = 0; i < 500; i++) begin
            randomize_ops();
            step("stream2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dsp_2_18x18s
